// File: rtl/multicycle_main_controller_pkg.sv
// Shared types for the multi-cycle MIPS main controller: FSM states,
// opcodes, control-field encodings and the packed control word.
package multicycle_ctrl_pkg;

   localparam int unsigned OPC_W = 6;

   typedef logic [OPC_W-1:0] opcode_t;

   localparam opcode_t OP_RTYPE = 6'b000000;
   localparam opcode_t OP_LW    = 6'b100011;
   localparam opcode_t OP_SW    = 6'b101011;
   localparam opcode_t OP_BEQ   = 6'b000100;
   localparam opcode_t OP_BNE   = 6'b000101;
   localparam opcode_t OP_ADDI  = 6'b001000;
   localparam opcode_t OP_J     = 6'b000010;
   localparam opcode_t OP_ORI   = 6'b001101;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC, ALUWB, BRANCH, IMMEXE, IMMWB, JUMP, TRAP
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_OR = 2'b11
   } alu_option_e;

   typedef enum logic [1:0] {
      SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RSVD = 2'b11
   } pc_src_e;

   typedef struct packed {
      logic        pc_write;
      logic        ir_write;
      logic        iord;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        reg_dst;
      logic        mem_to_reg;
      logic        alu_src_a;
      alu_src_b_e  alu_src_b;
      alu_option_e alu_option;
      logic        imm_src;
      logic        branch;
      logic        eq_branch;
      pc_src_e     pc_src;
      logic        illegal_op;
      logic        instr_retired;
   } ctrl_word_t;

   function automatic logic is_known_op(input opcode_t op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_ORI};
   endfunction

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Controller <-> datapath bundle: opcode/memory handshake in, control word out.
interface multicycle_main_controller_if #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned CNT_W    = 32
);
   logic [OPCODE_W-1:0] operation_code;
   logic                mem_ready;
   logic                pc_write;
   logic                ir_write;
   logic                iord;
   logic                mem_read;
   logic                mem_write;
   logic                reg_write;
   logic                reg_dst;
   logic                mem_to_reg;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_option;
   logic                imm_src;
   logic                branch;
   logic                eq_branch;
   logic [1:0]          pc_src;
   logic                illegal_op;
   logic                instr_retired;
   logic [CNT_W-1:0]    retired_count;

   modport master (
      input  operation_code, mem_ready,
      output pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_option, imm_src, branch,
             eq_branch, pc_src, illegal_op, instr_retired, retired_count
   );

   modport slave (
      output operation_code, mem_ready,
      input  pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_option, imm_src, branch,
             eq_branch, pc_src, illegal_op, instr_retired, retired_count
   );
endinterface

// File: rtl/multicycle_main_controller_output_decoder.sv
// Combinational control-word decode from FSM state, opcode and memory ready.
module multicycle_ctrl_output_decoder
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
   input  state_e     state,
   input  opcode_t    opcode,
   input  logic       mem_ready,
   output ctrl_word_t ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_option = ALU_ADD;
            ctrl.ir_write   = mem_ready;
            ctrl.pc_write   = mem_ready;
         end
         DECODE: begin
            ctrl.alu_src_b  = SRCB_IMM_SH2;
            ctrl.alu_option = ALU_ADD;
            ctrl.imm_src    = 1'b1;
            // unknown opcodes retire here as a NOP when trapping is disabled
            ctrl.instr_retired = (TRAP_ON_ILLEGAL == 0) && !is_known_op(opcode);
         end
         MEMADR: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_IMM;
            ctrl.imm_src    = 1'b1;
            ctrl.alu_option = ALU_ADD;
         end
         MEMRD: begin
            ctrl.iord     = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         MEMWB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.mem_to_reg    = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         MEMWR: begin
            ctrl.iord          = 1'b1;
            ctrl.mem_write     = 1'b1;
            ctrl.instr_retired = mem_ready;
         end
         EXEC: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_RT;
            ctrl.alu_option = ALU_FUNCT;
         end
         ALUWB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.reg_dst       = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.alu_option    = ALU_SUB;
            ctrl.branch        = 1'b1;
            ctrl.pc_src        = PCSRC_ALUOUT;
            ctrl.eq_branch     = (opcode == OP_BEQ);
            ctrl.instr_retired = 1'b1;
         end
         IMMEXE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            if (opcode == OP_ORI) begin
               ctrl.alu_option = ALU_OR;
               ctrl.imm_src    = 1'b0;
            end else begin
               ctrl.alu_option = ALU_ADD;
               ctrl.imm_src    = 1'b1;
            end
         end
         IMMWB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.instr_retired = 1'b1;
         end
         JUMP: begin
            ctrl.pc_write      = 1'b1;
            ctrl.pc_src        = PCSRC_JUMP;
            ctrl.instr_retired = 1'b1;
         end
         TRAP: ctrl.illegal_op = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_main_controller.sv
// Multi-cycle MIPS main controller: state register, next-state logic and
// retired-instruction counter; control outputs come from the output decoder.
module multicycle_main_controller
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W        = 6,
   parameter int unsigned CNT_W           = 32,
   parameter int unsigned MEM_WAIT        = 1,
   parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
   input logic                      clk,
   input logic                      rst_n,
   multicycle_main_controller_if.master bus
);

   state_e           state_q, state_d;
   opcode_t          opcode;
   logic             mem_rdy;
   ctrl_word_t       ctrl;
   logic [CNT_W-1:0] retired_count_q;

   assign opcode  = OPC_W'(bus.operation_code);
   assign mem_rdy = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   state_d = FETCH;
         FETCH:  if (mem_rdy) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_RTYPE:      state_d = EXEC;
               OP_LW, OP_SW:  state_d = MEMADR;
               OP_BEQ, OP_BNE: state_d = BRANCH;
               OP_ADDI, OP_ORI: state_d = IMMEXE;
               OP_J:          state_d = JUMP;
               default:       state_d = (TRAP_ON_ILLEGAL != 0) ? TRAP : FETCH;
            endcase
         end
         MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  if (mem_rdy) state_d = MEMWB;
         MEMWR:  if (mem_rdy) state_d = FETCH;
         EXEC:   state_d = ALUWB;
         IMMEXE: state_d = IMMWB;
         MEMWB, ALUWB, BRANCH, IMMWB, JUMP: state_d = FETCH;
         TRAP:   state_d = TRAP;
         default: state_d = IDLE;
      endcase
   end

   multicycle_ctrl_output_decoder #(
      .TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)
   ) u_output_decoder (
      .state    (state_q),
      .opcode   (opcode),
      .mem_ready(mem_rdy),
      .ctrl     (ctrl)
   );

   // counter bumps on the same edge that ends the retiring cycle; wraps freely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 retired_count_q <= '0;
      else if (ctrl.instr_retired) retired_count_q <= retired_count_q + CNT_W'(1);
   end

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.iord          = ctrl.iord;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_option    = ctrl.alu_option;
   assign bus.imm_src       = ctrl.imm_src;
   assign bus.branch        = ctrl.branch;
   assign bus.eq_branch     = ctrl.eq_branch;
   assign bus.pc_src        = ctrl.pc_src;
   assign bus.illegal_op    = ctrl.illegal_op;
   assign bus.instr_retired = ctrl.instr_retired;
   assign bus.retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Scoreboard bench: per-cycle expected control vectors built from the
// instruction-level rules, plus a wrap/no-wait/no-trap variant checked per retire.
module tb_multicycle_main_controller;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   logic clk = 1'b0;
   logic rst_n, rst_n2;
   always #5 clk = ~clk;

   multicycle_main_controller_if #(.OPCODE_W(6), .CNT_W(32)) if1 ();
   multicycle_main_controller_if #(.OPCODE_W(6), .CNT_W(4))  if2 ();

   multicycle_main_controller #(
      .OPCODE_W(6), .CNT_W(32), .MEM_WAIT(1), .TRAP_ON_ILLEGAL(1)
   ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   multicycle_main_controller #(
      .OPCODE_W(6), .CNT_W(4), .MEM_WAIT(0), .TRAP_ON_ILLEGAL(0)
   ) dut2 (.clk(clk), .rst_n(rst_n2), .bus(if2));

   typedef struct packed {
      logic        pc_write, ir_write, iord, mem_read, mem_write;
      logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0]  alu_src_b, alu_option;
      logic        imm_src, branch, eq_branch;
      logic [1:0]  pc_src;
      logic        illegal_op, instr_retired;
      logic [31:0] count;
   } exp_t;

   typedef struct {
      int         lat;
      logic [3:0] cnt;
   } ret_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        q1[$];
   ret_t        q2[$];
   logic [31:0] cnt_m;
   logic [3:0]  cnt2;
   int          cyc2;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t sample1();
      exp_t a;
      a.pc_write      = if1.pc_write;
      a.ir_write      = if1.ir_write;
      a.iord          = if1.iord;
      a.mem_read      = if1.mem_read;
      a.mem_write     = if1.mem_write;
      a.reg_write     = if1.reg_write;
      a.reg_dst       = if1.reg_dst;
      a.mem_to_reg    = if1.mem_to_reg;
      a.alu_src_a     = if1.alu_src_a;
      a.alu_src_b     = if1.alu_src_b;
      a.alu_option    = if1.alu_option;
      a.imm_src       = if1.imm_src;
      a.branch        = if1.branch;
      a.eq_branch     = if1.eq_branch;
      a.pc_src        = if1.pc_src;
      a.illegal_op    = if1.illegal_op;
      a.instr_retired = if1.instr_retired;
      a.count         = if1.retired_count;
      return a;
   endfunction

   // Monitor for the main controller: one expected vector per cycle.
   always @(negedge clk) begin
      if (q1.size() > 0) begin
         exp_t e;
         e = q1.pop_front();
         check("ctrl_cycle", 64'(sample1()), 64'(e));
      end
   end

   // Monitor for the variant: cycles between retirements and count at retire.
   always @(negedge clk) begin
      if (!rst_n2) cyc2 = 0;
      else begin
         cyc2++;
         if (if2.instr_retired) begin
            if (q2.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_retire2: got retire expected none at %0t", $time);
            end else begin
               ret_t r;
               r = q2.pop_front();
               check("latency2", 64'(cyc2), 64'(r.lat));
               check("count2", 64'(if2.retired_count), 64'(r.cnt));
               check("illegal2", 64'(if2.illegal_op), 64'd0);
            end
            cyc2 = 0;
         end
      end
   end

   // Queue an expectation for the current cycle and advance to the next.
   task automatic push(input exp_t e);
      e.count = cnt_m;
      q1.push_back(e);
      if (e.instr_retired) cnt_m++;
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_ready();
      if1.mem_ready = 1'($urandom);
   endtask

   task automatic reset1();
      exp_t e;
      if1.mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("reset_outputs", 64'(sample1()), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt_m = '0;
      e = '0;
      push(e);
   endtask

   task automatic ph_fetch(input int waits);
      exp_t e;
      for (int i = 0; i <= waits; i++) begin
         if1.mem_ready = (i == waits);
         e = '0;
         e.mem_read  = 1'b1;
         e.alu_src_b = 2'b01;
         e.pc_write  = (i == waits);
         e.ir_write  = (i == waits);
         push(e);
      end
   endtask

   task automatic ph_decode();
      exp_t e;
      rnd_ready();
      e = '0;
      e.alu_src_b = 2'b11;
      e.imm_src   = 1'b1;
      push(e);
   endtask

   task automatic ph_memadr();
      exp_t e;
      rnd_ready();
      e = '0;
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'b10;
      e.imm_src   = 1'b1;
      push(e);
   endtask

   task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
      exp_t e;
      if1.operation_code = op;
      ph_fetch(fw);
      ph_decode();
      case (op)
         OP_RTYPE: begin
            rnd_ready(); e = '0; e.alu_src_a = 1'b1; e.alu_option = 2'b10; push(e);
            rnd_ready(); e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_retired = 1'b1; push(e);
         end
         OP_LW, OP_SW: begin
            ph_memadr();
            for (int i = 0; i <= mw; i++) begin
               if1.mem_ready = (i == mw);
               e = '0;
               e.iord = 1'b1;
               if (op == OP_LW) e.mem_read = 1'b1;
               else begin
                  e.mem_write     = 1'b1;
                  e.instr_retired = (i == mw);
               end
               push(e);
            end
            if (op == OP_LW) begin
               rnd_ready(); e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_retired = 1'b1; push(e);
            end
         end
         OP_BEQ, OP_BNE: begin
            rnd_ready(); e = '0;
            e.alu_src_a = 1'b1; e.alu_option = 2'b01; e.branch = 1'b1; e.pc_src = 2'b01;
            e.eq_branch = (op == OP_BEQ); e.instr_retired = 1'b1;
            push(e);
         end
         OP_ADDI, OP_ORI: begin
            rnd_ready(); e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            if (op == OP_ORI) e.alu_option = 2'b11;
            else e.imm_src = 1'b1;
            push(e);
            rnd_ready(); e = '0; e.reg_write = 1'b1; e.instr_retired = 1'b1; push(e);
         end
         OP_J: begin
            rnd_ready(); e = '0; e.pc_write = 1'b1; e.pc_src = 2'b10; e.instr_retired = 1'b1; push(e);
         end
         default: begin
            for (int i = 0; i < 10; i++) begin
               rnd_ready(); e = '0; e.illegal_op = 1'b1; push(e);
            end
         end
      endcase
   endtask

   // Variant has no memory wait and retires unknown opcodes after decode.
   function automatic int lat2(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_ORI, OP_SW: return 4;
         OP_LW:                            return 5;
         OP_BEQ, OP_BNE, OP_J:             return 3;
         default:                          return 2;
      endcase
   endfunction

   task automatic run2(input logic [5:0] op, input int extra);
      ret_t r;
      if2.operation_code = op;
      r.lat = lat2(op) + extra;
      r.cnt = cnt2;
      q2.push_back(r);
      cnt2 = cnt2 + 4'd1;
      repeat (r.lat) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops [8];
      logic [5:0] seq2 [6];
      exp_t e;
      ops  = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_ORI};
      seq2 = '{OP_BAD, OP_LW, OP_SW, OP_RTYPE, OP_ORI, OP_BEQ};
      rst_n2 = 1'b0;
      if2.operation_code = OP_J;
      if2.mem_ready = 1'b0;
      if1.operation_code = OP_RTYPE;

      reset1();
      do_instr(OP_RTYPE, 0, 0);
      do_instr(OP_LW, 0, 3);
      do_instr(OP_BNE, 0, 0);
      do_instr(OP_BEQ, 0, 0);
      do_instr(OP_ORI, 0, 0);
      do_instr(OP_ADDI, 0, 0);
      do_instr(OP_J, 2, 0);
      do_instr(OP_SW, 1, 2);
      for (int i = 0; i < 30; i++)
         do_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3));
      do_instr(OP_BAD, 0, 0);
      @(negedge clk);
      #1;
      check("q1_drained", 64'(q1.size()), 64'd0);

      // abort a store while it is waiting on memory
      reset1();
      do_instr(OP_J, 0, 0);
      do_instr(OP_RTYPE, 1, 0);
      if1.operation_code = OP_SW;
      ph_fetch(0);
      ph_decode();
      ph_memadr();
      if1.mem_ready = 1'b0;
      e = '0; e.iord = 1'b1; e.mem_write = 1'b1;
      push(e);
      e.count = cnt_m;
      q1.push_back(e);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_mem_write", 64'(if1.mem_write), 64'd0);
      check("abort_iord", 64'(if1.iord), 64'd0);
      check("abort_count", 64'(if1.retired_count), 64'd0);
      check("abort_all_zero", 64'(sample1()), 64'd0);
      check("q1_empty_at_abort", 64'(q1.size()), 64'd0);

      // variant: 4-bit counter wrap, mem_ready ignored, unknown opcode retires
      cnt2 = '0;
      @(posedge clk);
      #1;
      rst_n2 = 1'b1;
      for (int i = 0; i < 16; i++) run2(OP_J, (i == 0) ? 1 : 0);
      check("wrap2", 64'(if2.retired_count), 64'(cnt2));
      for (int i = 0; i < 6; i++) run2(seq2[i], 0);
      check("final_count2", 64'(if2.retired_count), 64'(cnt2));
      check("q2_drained", 64'(q2.size()), 64'd0);
      rst_n2 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
